// File: rtl/tile_drain_pkg.sv
// Shared configuration for the tile datapath: array geometry, accumulator
// width, drain FIFO depth and the drain FSM state encoding.
package tile_drain_pkg;

  localparam int ACC_W            = 32;
  localparam int ARRAY_N          = 4;
  localparam int DRAIN_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with registered occupancy count and a combinational
// head word. DEPTH must be a power of two.
module drain_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          full;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop));

endmodule

// File: rtl/tile_drain.sv
// Streams count words of a tile BRAM out on a valid/ready port, prefetching
// reads into a 4-entry FIFO to hide the one-cycle BRAM read latency.
module tile_drain
  import tile_drain_pkg::*;
#(
  parameter int W     = ACC_W,
  parameter int DEPTH = ARRAY_N * ARRAY_N
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_drain,
  input  logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       bram_re,
  output logic [$clog2(DEPTH)-1:0]   bram_raddr,
  input  logic [W-1:0]               bram_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_last
);

  // Stream handshake: a word transfers on any rising edge where out_valid
  // and out_ready are both high; while out_valid is high and out_ready low,
  // out_data and out_last hold.

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(DRAIN_FIFO_DEPTH) + 1;

  drain_state_e   state;
  drain_state_e   state_nxt;
  logic [CW-1:0]  cnt_l;
  logic [CW-1:0]  cnt_sat;
  logic [CW-1:0]  issued;
  logic [CW-1:0]  sent;
  logic [AW-1:0]  rd_addr;
  logic           re_q;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] credit_used;
  logic           fifo_empty;
  logic           hs;
  logic           last_word;
  logic           last_hs;

  // A request of 0, or anything beyond the BRAM, drains the whole tile.
  assign cnt_sat = (count == '0 || count > CW'(DEPTH)) ? CW'(DEPTH) : count;

  // Reads in flight (re_q) still need a FIFO slot, so they count as used.
  assign credit_used = fifo_count + FCW'(re_q);
  assign out_valid   = !fifo_empty;
  assign hs          = out_valid && out_ready;
  assign last_word   = (sent == cnt_l - CW'(1));
  assign out_last    = out_valid && last_word;
  assign last_hs     = hs && last_word;
  assign bram_raddr  = rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_drain) state_nxt = S_RUN;
      S_RUN: begin
        if (last_hs)                                  state_nxt = S_IDLE;
        else if (issued + CW'(bram_re) == cnt_l)      state_nxt = S_FLUSH;
      end
      S_FLUSH: if (last_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    bram_re = (state == S_RUN) && (issued < cnt_l) &&
              (credit_used < FCW'(DRAIN_FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_l      <= '0;
      issued     <= '0;
      sent       <= '0;
      rd_addr    <= '0;
      re_q       <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      re_q       <= bram_re;
      drain_done <= last_hs;
      if (state == S_IDLE && start_drain) begin
        cnt_l   <= cnt_sat;
        issued  <= '0;
        sent    <= '0;
        rd_addr <= '0;
      end else begin
        if (bram_re) begin
          issued  <= issued + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
        if (hs) sent <= sent + 1'b1;
      end
    end
  end

  drain_fifo #(
    .W     (W),
    .DEPTH (DRAIN_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (re_q),
    .push_data (bram_rdata),
    .pop       (hs),
    .head      (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_tile_drain.sv
// Directed bench for tile_drain: a vector table of drains with hand-computed
// timing plus hand-written reset and idle sequences.
module tb_tile_drain;
  import tile_drain_pkg::*;

  localparam int W     = ACC_W;
  localparam int DEPTH = ARRAY_N * ARRAY_N;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_drain = 1'b0;
  logic [CW-1:0] count = '0;
  logic          busy;
  logic          drain_done;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [W-1:0]  bram_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_last;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  tile_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_drain (start_drain),
    .count       (count),
    .busy        (busy),
    .drain_done  (drain_done),
    .bram_re     (bram_re),
    .bram_raddr  (bram_raddr),
    .bram_rdata  (bram_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  // BRAM model preloaded with mem[i] = i + 100, one-cycle registered read
  always @(posedge clk) if (bram_re) bram_rdata <= W'(bram_raddr) + W'(100);

  // ---------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ready mode 0: always; 1: pattern 1,0,0,1,0,1; 2: low for cycles 1..10;
  // 3: always, with start re-pulsed mid-drain and on the last handshake
  function automatic logic ready_for(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      1:       return pat[(cyc - 1) % 6];
      2:       return (cyc > 10);
      default: return 1'b1;
    endcase
  endfunction

  typedef struct {
    string name;
    int    cnt;
    int    mode;
    int    exp_n;
    int    exp_done;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver + monitor for one drain
  task automatic run_drain(input string name, input int cnt, input int mode,
                           input int exp_n, input int exp_done);
    int cyc, words, done_n, done_cyc, issues, max_fc, first_valid;
    logic prev_stall, prev_last;
    logic [W-1:0] prev_data, e;
    cyc = 0; words = 0; done_n = 0; done_cyc = -1; issues = 0; max_fc = 0;
    first_valid = -1; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back(W'(100 + i));

    @(posedge clk); #1;
    count = CW'(cnt);
    start_drain = 1'b1;
    out_ready = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start_drain = (mode == 3) && (cyc == 3 || cyc == exp_n + 2);
      out_ready = ready_for(mode, cyc);
      @(negedge clk);
      if (bram_re) begin
        if (issues == 0) chk({name, " first_read_cycle"}, cyc, 1);
        chk({name, " raddr"}, bram_raddr, issues);
        issues++;
      end
      if (mode == 2 && cyc == 10) chk({name, " reads_while_stalled"}, issues, 4);
      if (int'(dut.fifo_count) > max_fc) max_fc = int'(dut.fifo_count);
      if (prev_stall) begin
        chk({name, " stall_data"}, out_data, prev_data);
        chk({name, " stall_last"}, out_last, prev_last);
      end
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk({name, " first_valid_cycle"}, cyc, 3);
        end
        chk({name, " out_last"}, out_last, (words == exp_n - 1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({name, " extra_word"}, out_data, 0);
        else begin
          e = exp_q.pop_front();
          chk({name, " out_data"}, out_data, e);
        end
        words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (drain_done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (!busy) break;
      if (cyc > 300) begin
        chk({name, " timeout"}, 1, 0);
        break;
      end
    end
    chk({name, " words"}, words, exp_n);
    chk({name, " done_pulses"}, done_n, 1);
    chk({name, " done_cycle"}, done_cyc, exp_done);
    chk({name, " busy_fall_cycle"}, cyc, exp_done);
    chk({name, " total_reads"}, issues, exp_n);
    chk({name, " fifo_over_4"}, (max_fc > 4), 0);
    start_drain = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, " idle_after_busy"}, busy, 0);
    chk({name, " idle_no_done"}, drain_done, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " busy"}, busy, 0);
    chk({name, " drain_done"}, drain_done, 0);
    chk({name, " bram_re"}, bram_re, 0);
    chk({name, " bram_raddr"}, bram_raddr, 0);
    chk({name, " out_valid"}, out_valid, 0);
    chk({name, " out_data"}, out_data, 0);
    chk({name, " out_last"}, out_last, 0);
  endtask

  // ---------------- test sequence
  initial begin
    vecs[0] = '{"cnt4",      4,  0, 4,  7};
    vecs[1] = '{"cnt0_full", 0,  0, 16, 19};
    vecs[2] = '{"toggle8",   8,  1, 8,  19};
    vecs[3] = '{"sat20",     20, 0, 16, 19};
    vecs[4] = '{"stall10",   8,  2, 8,  19};
    vecs[5] = '{"restart4",  4,  3, 4,  7};
    vecs[6] = '{"cnt1",      1,  0, 1,  4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("after_reset");

    for (int v = 0; v < 7; v++)
      run_drain(vecs[v].name, vecs[v].cnt, vecs[v].mode, vecs[v].exp_n, vecs[v].exp_done);

    // asynchronous reset in cycle 4 of an 8-word drain
    @(posedge clk); #1;
    count = CW'(8);
    start_drain = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start_drain = 1'b0;
    end
    chk("mid_drain valid_before_reset", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset no_done", drain_done, 0);
      chk("post_reset no_busy", busy, 0);
    end
    run_drain("post_reset_cnt2", 2, 0, 2, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
